// File: rtl/uart_echo_fifo.sv
// UART receiver feeding a FIFO that is echoed back out of a UART transmitter.
// RX never stalls; bytes that arrive while the FIFO is full are dropped and flagged.
module uart_echo_fifo #(
  parameter int CLK_HZ     = 12000000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  output logic                          tx,
  input  logic                          echo_en,
  input  logic                          clear_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          tx_busy,
  output logic                          overrun,
  output logic                          frame_err,
  output logic                          parity_err
);

  localparam int DIV_CALC = (CLK_HZ + BAUD * 8) / (BAUD * 16);
  localparam int DIV      = (DIV_CALC < 1) ? 1 : DIV_CALC;
  localparam int DW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int BW       = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  logic [DW-1:0] divCnt_q;
  logic          tick;

  assign tick = (divCnt_q == DW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      divCnt_q <= '0;
    end else if (tick) begin
      divCnt_q <= '0;
    end else begin
      divCnt_q <= divCnt_q + DW'(1);
    end
  end

  // rxPrev_q lets IDLE see a genuine high-to-low transition on the synchronized line
  logic rxMeta_q, rxSync_q, rxPrev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
      rxPrev_q <= 1'b1;
    end else begin
      rxMeta_q <= rx;
      rxSync_q <= rxMeta_q;
      rxPrev_q <= rxSync_q;
    end
  end

  state_e                 rxState_q;
  logic [3:0]             rxTick_q;
  logic [BW-1:0]          rxBit_q;
  logic [DATA_BITS-1:0]   rxShift_q;
  logic                   rxPar_q;
  logic                   rxSample;
  logic                   rxParExp;
  logic                   rxPush;
  logic                   rxFrameErr;
  logic                   rxParityErr;

  assign rxSample = tick && (rxTick_q == 4'd15);
  assign rxParExp = (PARITY == 2) ? ~(^rxShift_q) : (^rxShift_q);

  always_comb begin
    rxPush      = 1'b0;
    rxFrameErr  = 1'b0;
    rxParityErr = 1'b0;
    if (rxState_q == ST_STOP && rxSample) begin
      if (!rxSync_q) begin
        rxFrameErr = 1'b1;
      end else if ((PARITY != 0) && (rxPar_q != rxParExp)) begin
        rxParityErr = 1'b1;
      end else begin
        rxPush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rxState_q <= ST_IDLE;
      rxTick_q  <= '0;
      rxBit_q   <= '0;
      rxShift_q <= '0;
      rxPar_q   <= 1'b0;
    end else begin
      case (rxState_q)
        ST_IDLE: begin
          if (rxPrev_q && !rxSync_q) begin
            rxState_q <= ST_START;
            rxTick_q  <= '0;
          end
        end
        ST_START: begin
          if (tick) begin
            if (rxTick_q == 4'd7) begin
              rxTick_q  <= '0;
              rxBit_q   <= '0;
              rxState_q <= rxSync_q ? ST_IDLE : ST_DATA;
            end else begin
              rxTick_q <= rxTick_q + 4'd1;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            rxTick_q <= rxTick_q + 4'd1;
            if (rxTick_q == 4'd15) begin
              rxShift_q <= {rxSync_q, rxShift_q[DATA_BITS-1:1]};
              if (rxBit_q == BW'(DATA_BITS - 1)) begin
                rxState_q <= (PARITY != 0) ? ST_PARITY : ST_STOP;
              end else begin
                rxBit_q <= rxBit_q + BW'(1);
              end
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            rxTick_q <= rxTick_q + 4'd1;
            if (rxTick_q == 4'd15) begin
              rxPar_q   <= rxSync_q;
              rxState_q <= ST_STOP;
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            rxTick_q <= rxTick_q + 4'd1;
            if (rxTick_q == 4'd15) begin
              rxState_q <= ST_IDLE;
            end
          end
        end
        default: rxState_q <= ST_IDLE;
      endcase
    end
  end

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wrPtr_q, rdPtr_q;
  logic [AW:0]          count_q;
  logic                 txPop;
  logic                 pushOk;
  state_e               txState_q;

  assign txPop  = (txState_q == ST_IDLE) && echo_en && (count_q != '0);
  // A pop in the same cycle frees the slot, so a full FIFO can still take the byte
  assign pushOk = rxPush && ((count_q < (AW + 1)'(FIFO_DEPTH)) || txPop);

  always_ff @(posedge clk) begin
    if (pushOk) begin
      mem[wrPtr_q] <= rxShift_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (pushOk) begin
        wrPtr_q <= wrPtr_q + AW'(1);
      end
      if (txPop) begin
        rdPtr_q <= rdPtr_q + AW'(1);
      end
      case ({pushOk, txPop})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky flags: a new error event in the clearing cycle wins over clear_err
  logic overrun_q, frameErr_q, parityErr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q   <= 1'b0;
      frameErr_q  <= 1'b0;
      parityErr_q <= 1'b0;
    end else begin
      overrun_q   <= (overrun_q & ~clear_err) | (rxPush & ~pushOk);
      frameErr_q  <= (frameErr_q & ~clear_err) | rxFrameErr;
      parityErr_q <= (parityErr_q & ~clear_err) | rxParityErr;
    end
  end

  logic [3:0]           txTick_q;
  logic [BW-1:0]        txBit_q;
  logic [DATA_BITS-1:0] txShift_q;
  logic                 txPar_q;
  logic                 tx_q;
  logic [DATA_BITS-1:0] txHead;
  logic                 txHeadPar;

  assign txHead    = mem[rdPtr_q];
  assign txHeadPar = (PARITY == 2) ? ~(^txHead) : (^txHead);

  always_ff @(posedge clk) begin
    if (rst) begin
      txState_q <= ST_IDLE;
      txTick_q  <= '0;
      txBit_q   <= '0;
      txShift_q <= '0;
      txPar_q   <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      case (txState_q)
        ST_IDLE: begin
          tx_q <= 1'b1;
          if (txPop) begin
            txShift_q <= txHead;
            txPar_q   <= txHeadPar;
            txTick_q  <= '0;
            txState_q <= ST_START;
            tx_q      <= 1'b0;
          end
        end
        ST_START: begin
          if (tick) begin
            txTick_q <= txTick_q + 4'd1;
            if (txTick_q == 4'd15) begin
              txBit_q   <= '0;
              tx_q      <= txShift_q[0];
              txState_q <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            txTick_q <= txTick_q + 4'd1;
            if (txTick_q == 4'd15) begin
              if (txBit_q == BW'(DATA_BITS - 1)) begin
                if (PARITY != 0) begin
                  tx_q      <= txPar_q;
                  txState_q <= ST_PARITY;
                end else begin
                  tx_q      <= 1'b1;
                  txState_q <= ST_STOP;
                end
              end else begin
                txBit_q   <= txBit_q + BW'(1);
                txShift_q <= txShift_q >> 1;
                tx_q      <= txShift_q[1];
              end
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            txTick_q <= txTick_q + 4'd1;
            if (txTick_q == 4'd15) begin
              tx_q      <= 1'b1;
              txState_q <= ST_STOP;
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            txTick_q <= txTick_q + 4'd1;
            if (txTick_q == 4'd15) begin
              txState_q <= ST_IDLE;
            end
          end
        end
        default: begin
          txState_q <= ST_IDLE;
          tx_q      <= 1'b1;
        end
      endcase
    end
  end

  assign tx         = tx_q;
  assign tx_busy    = (txState_q != ST_IDLE);
  assign fifo_count = count_q;
  assign overrun    = overrun_q;
  assign frame_err  = frameErr_q;
  assign parity_err = parityErr_q;

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Directed bench for uart_echo_fifo: an 8N1 instance and an 8E1 instance at DIV=1,
// with tx monitors that pop expected echo bytes from scoreboard queues.
module tb_uart_echo_fifo;

  logic       clk;
  logic       rst;
  logic       rx, rxP;
  logic       echo_en, clear_err;
  logic       tx, txP;
  logic       tx_busy, tx_busyP;
  logic       overrun, overrunP;
  logic       frame_err, frame_errP;
  logic       parity_err, parity_errP;
  logic [4:0] fifo_count, fifo_countP;

  int         testsRun = 0;
  int         testsFailed = 0;
  logic [7:0] expQ[$];
  logic [7:0] expQP[$];
  int         frames = 0;
  int         framesP = 0;
  logic [9:0] monBits;
  logic [10:0] monBitsP;
  longint     cycleCnt = 0;
  longint     prevStart = 0;
  int         lastGap = 0;
  bit         frameAborted = 0;
  int         base;

  uart_echo_fifo #(
    .CLK_HZ(1843200), .BAUD(115200), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(16)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx), .tx(tx), .echo_en(echo_en), .clear_err(clear_err),
    .fifo_count(fifo_count), .tx_busy(tx_busy), .overrun(overrun),
    .frame_err(frame_err), .parity_err(parity_err)
  );

  uart_echo_fifo #(
    .CLK_HZ(1843200), .BAUD(115200), .DATA_BITS(8), .PARITY(1), .FIFO_DEPTH(16)
  ) dutPar (
    .clk(clk), .rst(rst), .rx(rxP), .tx(txP), .echo_en(echo_en), .clear_err(clear_err),
    .fifo_count(fifo_countP), .tx_busy(tx_busyP), .overrun(overrunP),
    .frame_err(frame_errP), .parity_err(parity_errP)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives one frame on rx (or rxP), each bit held 16 cycles, then a short idle
  task automatic applyStimulus(input logic [7:0] data, input bit onPar,
                               input logic parBit, input logic stopBit);
    logic [10:0] bits;
    int n;
    bits      = '1;
    bits[0]   = 1'b0;
    bits[8:1] = data;
    if (onPar) begin
      bits[9]  = parBit;
      bits[10] = stopBit;
      n = 11;
    end else begin
      bits[9] = stopBit;
      n = 10;
    end
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (onPar) rxP = bits[i]; else rx = bits[i];
      repeat (15) @(negedge clk);
    end
    @(negedge clk);
    if (onPar) rxP = 1'b1; else rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic waitFrames(input string tag, input bit onPar, input int target,
                            input int budget);
    int n = 0;
    while (((onPar ? framesP : frames) < target) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, onPar ? framesP : frames, target);
  endtask

  // 8N1 tx monitor: samples mid-bit on falling clock edges
  initial begin
    forever begin
      @(negedge tx);
      lastGap   = int'(cycleCnt - prevStart);
      prevStart = cycleCnt;
      for (int i = 0; i < 10; i++) begin
        repeat ((i == 0) ? 8 : 16) @(negedge clk);
        monBits[i] = tx;
      end
      if (frameAborted) begin
        frameAborted = 0;
      end else begin
        checkOutput("echo_start", monBits[0], 1'b0);
        checkOutput("echo_stop", monBits[9], 1'b1);
        checkOutput("echo_expected", expQ.size() > 0, 1'b1);
        if (expQ.size() > 0) checkOutput("echo_data", monBits[8:1], expQ.pop_front());
      end
      frames++;
    end
  end

  // 8E1 tx monitor
  initial begin
    logic [7:0] expByte;
    forever begin
      @(negedge txP);
      for (int i = 0; i < 11; i++) begin
        repeat ((i == 0) ? 8 : 16) @(negedge clk);
        monBitsP[i] = txP;
      end
      checkOutput("par_echo_start", monBitsP[0], 1'b0);
      checkOutput("par_echo_stop", monBitsP[10], 1'b1);
      checkOutput("par_echo_expected", expQP.size() > 0, 1'b1);
      if (expQP.size() > 0) begin
        expByte = expQP.pop_front();
        checkOutput("par_echo_data", monBitsP[8:1], expByte);
        checkOutput("par_echo_parity", monBitsP[9], ^expByte);
      end
      framesP++;
    end
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; rx = 1'b1; rxP = 1'b1; echo_en = 1'b0; clear_err = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_tx", tx, 1'b1);
    checkOutput("rst_tx_busy", tx_busy, 1'b0);
    checkOutput("rst_count", fifo_count, 5'd0);
    checkOutput("rst_overrun", overrun, 1'b0);
    checkOutput("rst_frame_err", frame_err, 1'b0);
    checkOutput("rst_parity_err", parity_err, 1'b0);
    checkOutput("rst_txP", txP, 1'b1);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    echo_en = 1'b1;
    expQ.push_back(8'hA5);
    applyStimulus(8'hA5, 0, 1'b0, 1'b1);
    waitFrames("a5_echo_seen", 0, 1, 400);
    checkOutput("a5_bits", monBits, 10'b1101001010);
    checkOutput("a5_count", fifo_count, 5'd0);
    checkOutput("a5_flags", {overrun, frame_err, parity_err}, 3'b000);
    repeat (20) @(negedge clk);

    // Start glitch shorter than half a bit must be ignored
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("glitch_count", fifo_count, 5'd0);
    checkOutput("glitch_flags", {overrun, frame_err, parity_err}, 3'b000);
    checkOutput("glitch_tx_busy", tx_busy, 1'b0);
    expQ.push_back(8'h42);
    applyStimulus(8'h42, 0, 1'b0, 1'b1);
    waitFrames("glitch_recover_echo", 0, 2, 400);
    repeat (20) @(negedge clk);

    // Even parity: 0x03 needs parity bit 0
    applyStimulus(8'h03, 1, 1'b1, 1'b1);
    checkOutput("par_bad_flag", parity_errP, 1'b1);
    checkOutput("par_bad_count", fifo_countP, 5'd0);
    checkOutput("par_bad_frame_err", frame_errP, 1'b0);
    expQP.push_back(8'h03);
    applyStimulus(8'h03, 1, 1'b0, 1'b1);
    waitFrames("par_good_echo", 1, 1, 400);
    checkOutput("par_sticky", parity_errP, 1'b1);
    repeat (20) @(negedge clk);

    echo_en = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) expQ.push_back(8'(i));
      applyStimulus(8'(i), 0, 1'b0, 1'b1);
    end
    checkOutput("full_count", fifo_count, 5'd16);
    checkOutput("full_overrun", overrun, 1'b1);
    checkOutput("full_tx_idle", tx_busy, 1'b0);
    base = frames;
    echo_en = 1'b1;
    waitFrames("drain_frames", 0, base + 16, 3200);
    checkOutput("drain_gap", lastGap, 161);
    checkOutput("drain_count", fifo_count, 5'd0);
    checkOutput("drain_overrun_sticky", overrun, 1'b1);
    checkOutput("drain_queue_empty", expQ.size(), 0);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    checkOutput("clear_overrun", overrun, 1'b0);
    repeat (20) @(negedge clk);

    base = frames;
    applyStimulus(8'h5A, 0, 1'b0, 1'b0);
    checkOutput("ferr_flag", frame_err, 1'b1);
    checkOutput("ferr_count", fifo_count, 5'd0);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    checkOutput("ferr_clear", frame_err, 1'b0);
    repeat (200) @(negedge clk);
    checkOutput("ferr_no_echo", frames, base);

    // Reset while transmitting data bit 3 of 0xC3 (a 0 bit), with one byte still queued
    applyStimulus(8'h11, 0, 1'b0, 1'b0);
    checkOutput("pre_rst_frame_err", frame_err, 1'b1);
    echo_en = 1'b0;
    applyStimulus(8'hC3, 0, 1'b0, 1'b1);
    applyStimulus(8'h3C, 0, 1'b0, 1'b1);
    checkOutput("pre_rst_count", fifo_count, 5'd2);
    frameAborted = 1;
    echo_en = 1'b1;
    begin
      int n = 0;
      while (tx !== 1'b0 && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    checkOutput("pre_rst_tx_start", tx, 1'b0);
    repeat (71) @(negedge clk);
    checkOutput("pre_rst_bit3", tx, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_tx", tx, 1'b1);
    checkOutput("midrst_tx_busy", tx_busy, 1'b0);
    checkOutput("midrst_count", fifo_count, 5'd0);
    checkOutput("midrst_flags", {overrun, frame_err, parity_err}, 3'b000);
    checkOutput("midrst_par_flag", parity_errP, 1'b0);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    checkOutput("post_rst_tx_idle", tx_busy, 1'b0);

    base = frames;
    expQ.push_back(8'h81);
    applyStimulus(8'h81, 0, 1'b0, 1'b1);
    waitFrames("post_rst_echo", 0, base + 1, 400);
    repeat (50) @(negedge clk);
    checkOutput("final_queue_empty", expQ.size() + expQP.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
